// File: rtl/cg_burst_gate.sv
// Per-channel clock gate: emits a programmed burst (or free-running clock) of CLK after an optional start delay.
// Latency: with DELAY=0 the first gated edge follows the START edge by one CLK; no backpressure, START while busy is dropped.
module cg_burst_gate #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int DLY_WIDTH = 8,
  parameter bit IDLE_HIGH = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CHANNELS-1:0]  START,
  input  logic [CHANNELS-1:0]  STOP,
  input  logic [CNT_WIDTH-1:0] COUNT,
  input  logic [DLY_WIDTH-1:0] DELAY,
  output logic [CHANNELS-1:0]  CLK_OUT,
  output logic [CHANNELS-1:0]  BUSY,
  output logic [CHANNELS-1:0]  DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [DLY_WIDTH-1:0] dly_q   [CHANNELS];
  logic [CHANNELS-1:0]  load;
  logic [CHANNELS-1:0]  en_d;
  logic [CHANNELS-1:0]  en_q;
  logic [CHANNELS-1:0]  busy_d;
  logic [CHANNELS-1:0]  done_d;

  // STOP has priority, so a simultaneous START in IDLE never loads
  assign load = START & ~STOP;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: if (load[i]) state_d[i] = (DELAY != '0) ? S_WAIT : S_RUN;
        S_WAIT: begin
          if (STOP[i])                            state_d[i] = S_IDLE;
          else if (dly_q[i] == DLY_WIDTH'(1))     state_d[i] = S_RUN;
        end
        S_RUN: begin
          // a zero count never reaches 1, so a free-running burst only ends on STOP
          if (STOP[i])                            state_d[i] = S_IDLE;
          else if (cnt_q[i] == CNT_WIDTH'(1))     state_d[i] = S_IDLE;
        end
        default:                                  state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      en_d[i]   = (state_d[i] == S_RUN);
      busy_d[i] = (state_d[i] != S_IDLE);
      done_d[i] = (state_q[i] != S_IDLE) && (state_d[i] == S_IDLE);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        dly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case (state_q[i])
          S_IDLE: begin
            if (load[i]) begin
              cnt_q[i] <= COUNT;
              dly_q[i] <= DELAY;
            end
          end
          S_WAIT:  if (dly_q[i] != '0) dly_q[i] <= dly_q[i] - DLY_WIDTH'(1);
          S_RUN:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q <= '0;
      BUSY <= '0;
      DONE <= '0;
    end else begin
      en_q <= en_d;
      BUSY <= busy_d;
      DONE <= done_d;
    end
  end

  // The latch is closed during the phase the gate passes, so en_q changes never reach CLK_OUT mid-phase
  for (genvar g = 0; g < CHANNELS; g++) begin : g_gate
    logic en_lat;
    if (IDLE_HIGH) begin : g_or
      always_latch begin
        if (RST)      en_lat = 1'b0;
        else if (CLK) en_lat = en_q[g];
      end
      assign CLK_OUT[g] = CLK | ~en_lat;
    end else begin : g_and
      always_latch begin
        if (RST)       en_lat = 1'b0;
        else if (!CLK) en_lat = en_q[g];
      end
      assign CLK_OUT[g] = CLK & en_lat;
    end
  end

endmodule
